// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core PC unit.
//   pc_state_e        : PC generator FSM state encoding (2-bit)
//   PC_SEL_*          : commit_sel encodings ([0] base=rs1, [1] offset=imm)
//   RST_VALUE_DEFAULT : default PC loaded on reset
package npc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pc_state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b10;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  localparam logic [31:0] RST_VALUE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target computation for a normal (non-trap, non-mret) commit.
// Optional feature macro: PC_RVC_EN (16-bit instruction support).
// Ports:
//   pc         in   current architectural PC (base when sel[0]=0)
//   rs1        in   rs1 operand (base when sel[0]=1)
//   imm        in   32-bit immediate, sign-extended to XLEN (offset when sel[1]=1)
//   sel        in   base/offset select
//   rvc        in   retired insn is 16-bit (only meaningful with PC_RVC_EN)
//   target     out  computed target, modulo 2^XLEN, bit 0 cleared for jalr
//   misaligned out  target violates instruction alignment
module pc_target_calc
  import npc_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ILEN_B = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [31:0]     imm,
  input  logic [1:0]      sel,
  input  logic            rvc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  assign imm_ext = XLEN'($signed(imm));

`ifndef PC_RVC_EN
  logic unused_rvc;
  assign unused_rvc = rvc;
`endif

  always_comb begin
`ifdef PC_RVC_EN
    step = rvc ? XLEN'(2) : XLEN'(ILEN_B);
`else
    step = XLEN'(ILEN_B);
`endif
    base   = sel[0] ? rs1 : pc;
    offset = sel[1] ? imm_ext : step;
    // Adder wraps silently; no overflow reporting.
    target = base + offset;
    if (sel == PC_SEL_JALR) begin
      target[0] = 1'b0;
    end
`ifdef PC_RVC_EN
    misaligned = target[0];
`else
    misaligned = |target[1:0];
`endif
  end

endmodule

// File: rtl/pc_gen.sv
// PC generator for the multicycle NPC core: owns the architectural PC, issues fetch requests
// to the IFU over valid/ready, and computes the next PC on each WBU commit.
// Optional feature macro: PC_RVC_EN (2-byte step for 16-bit insns, 2-byte alignment).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ifu_valid/ready fetch request handshake; ifu_pc is the fetch address
//   commit_*        retire pulse with next-PC selection operands
//   trap_req        enter trap (pc <= mtvec), highest priority
//   mret_req        return from trap (pc <= mepc)
//   mtvec, mepc     trap vector / return address
//   misalign        one-cycle pulse, computed target misaligned; misalign_addr holds it
//   pc              architectural PC
//   busy            high once out of ST_BOOT
module pc_gen
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RST_VALUE = XLEN'(RST_VALUE_DEFAULT),
  parameter int unsigned     ILEN_B    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_pc,
  input  logic            commit_valid,
  input  logic [1:0]      commit_sel,
  input  logic [XLEN-1:0] commit_rs1,
  input  logic [31:0]     commit_imm,
  input  logic            commit_rvc,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] pc,
  output logic            busy
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            ifu_valid_q;
  logic            misalign_q;
  logic [XLEN-1:0] misalign_addr_q;
  logic            busy_q;

  logic [XLEN-1:0] target;
  logic            target_misaligned;

  pc_target_calc #(
    .XLEN   (XLEN),
    .ILEN_B (ILEN_B)
  ) u_target_calc (
    .pc         (pc_q),
    .rs1        (commit_rs1),
    .imm        (commit_imm),
    .sel        (commit_sel),
    .rvc        (commit_rvc),
    .target     (target),
    .misaligned (target_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_q            <= RST_VALUE;
      ifu_valid_q     <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        ST_BOOT: begin
          state_q     <= ST_ISSUE;
          ifu_valid_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        ST_ISSUE: begin
          // pc_q only moves in ST_WAIT, so ifu_pc is stable under backpressure.
          if (ifu_ready) begin
            state_q     <= ST_WAIT;
            ifu_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (commit_valid) begin
            state_q     <= ST_ISSUE;
            ifu_valid_q <= 1'b1;
            if (trap_req) begin
              pc_q <= mtvec;
            end else if (mret_req) begin
              pc_q <= mepc;
            end else if (target_misaligned) begin
              // Misaligned target takes the trap entry path.
              pc_q            <= mtvec;
              misalign_q      <= 1'b1;
              misalign_addr_q <= target;
            end else begin
              pc_q <= target;
            end
          end
        end
        default: begin
          state_q     <= ST_BOOT;
          ifu_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_valid     = ifu_valid_q;
  assign ifu_pc        = pc_q;
  assign pc            = pc_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
  assign busy          = busy_q;

endmodule
